// File: rtl/window_generator_pkg.sv
// Shared definitions for the 3x3 window generator: default image geometry,
// window bus sizing and the element index map (k = 3*row + col).
package window_generator_pkg;
   localparam int DEFAULT_PIXEL_WIDTH  = 8;
   localparam int DEFAULT_IMAGE_WIDTH  = 640;
   localparam int DEFAULT_IMAGE_HEIGHT = 480;
   localparam int WINDOW_ROWS          = 3;
   localparam int WINDOW_COLS          = 3;
   localparam int WINDOW_PIXELS        = WINDOW_ROWS * WINDOW_COLS;
   localparam int WINDOW_BUS_WIDTH     = WINDOW_PIXELS * DEFAULT_PIXEL_WIDTH;

   // Row 0 is the oldest (top) row, column 0 the oldest (left) column.
   localparam int WIN_TOP_LEFT   = 0;
   localparam int WIN_TOP_MID    = 1;
   localparam int WIN_TOP_RIGHT  = 2;
   localparam int WIN_MID_LEFT   = 3;
   localparam int WIN_CENTRE     = 4;
   localparam int WIN_MID_RIGHT  = 5;
   localparam int WIN_BOT_LEFT   = 6;
   localparam int WIN_BOT_MID    = 7;
   localparam int WIN_BOT_RIGHT  = 8;

   function automatic int win_idx(input int r, input int c);
      return WINDOW_COLS * r + c;
   endfunction
endpackage

// File: rtl/window_generator_line_buffer.sv
// DEPTH x WIDTH line memory: synchronous write, registered read; a read and
// write to the same address in one cycle returns the old contents.
module window_generator_line_buffer
   import window_generator_pkg::*;
#(
   parameter int DEPTH = DEFAULT_IMAGE_WIDTH,
   parameter int WIDTH = 2 * DEFAULT_PIXEL_WIDTH,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
      r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;
endmodule

// File: rtl/window_generator.sv
// Streaming 3x3 neighbourhood generator: two line buffers (packed into one
// memory) feed a shifting 3x3 register array; one window per pixel at row>=2,col>=2.
module window_generator
   import window_generator_pkg::*;
#(
   parameter int IMAGE_WIDTH  = DEFAULT_IMAGE_WIDTH,
   parameter int IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT,
   parameter int PIXEL_WIDTH  = DEFAULT_PIXEL_WIDTH
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 frame_start,
   input  logic [PIXEL_WIDTH-1:0]               pixel_in,
   input  logic                                 pixel_valid,
   output logic [WINDOW_PIXELS*PIXEL_WIDTH-1:0] pixel_values,
   output logic                                 window_valid,
   output logic                                 window_last
);
   localparam int CW = $clog2(IMAGE_WIDTH);
   localparam int RW = $clog2(IMAGE_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);

   logic [CW-1:0]            r_col, w_col_cur, w_col_next;
   logic [RW-1:0]            r_row, w_row_cur, w_row_next;
   logic                     r_valid, r_last;
   logic [2*PIXEL_WIDTH-1:0] w_lb_rd, w_lb_wr;
   logic [PIXEL_WIDTH-1:0]   w_new_col [WINDOW_ROWS];

   // frame_start forces the pixel accepted in the same cycle to be (0,0).
   assign w_col_cur = frame_start ? '0 : r_col;
   assign w_row_cur = frame_start ? '0 : r_row;

   always_comb begin
      w_col_next = w_col_cur;
      w_row_next = w_row_cur;
      if (pixel_valid) begin
         if (w_col_cur == COL_LAST) begin
            w_col_next = '0;
            w_row_next = (w_row_cur == ROW_LAST) ? '0 : w_row_cur + 1'b1;
         end else begin
            w_col_next = w_col_cur + 1'b1;
         end
      end
   end

   // Read address runs one step ahead so the RAM output already holds
   // {lb1[col], lb0[col]} when the pixel for col arrives.
   window_generator_line_buffer #(
      .DEPTH (IMAGE_WIDTH),
      .WIDTH (2 * PIXEL_WIDTH)
   ) u_line_buffer (
      .clk       (clk),
      .i_wr_en   (pixel_valid),
      .i_wr_addr (w_col_cur),
      .i_wr_data (w_lb_wr),
      .i_rd_addr (w_col_next),
      .o_rd_data (w_lb_rd)
   );

   assign w_lb_wr      = {w_lb_rd[PIXEL_WIDTH-1:0], pixel_in};
   assign w_new_col[0] = w_lb_rd[2*PIXEL_WIDTH-1:PIXEL_WIDTH];
   assign w_new_col[1] = w_lb_rd[PIXEL_WIDTH-1:0];
   assign w_new_col[2] = pixel_in;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_col   <= '0;
         r_row   <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         r_col   <= w_col_next;
         r_row   <= w_row_next;
         r_valid <= pixel_valid && (w_row_cur >= RW'(2)) && (w_col_cur >= CW'(2));
         r_last  <= pixel_valid && (w_row_cur == ROW_LAST) && (w_col_cur == COL_LAST);
      end
   end

   for (genvar gi = 0; gi < WINDOW_ROWS; gi++) begin : g_row
      logic [PIXEL_WIDTH-1:0] r_pix [WINDOW_COLS];

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int c = 0; c < WINDOW_COLS; c++) begin
               r_pix[c] <= '0;
            end
         end else if (pixel_valid) begin
            r_pix[0] <= r_pix[1];
            r_pix[1] <= r_pix[2];
            r_pix[2] <= w_new_col[gi];
         end
      end

      for (genvar gj = 0; gj < WINDOW_COLS; gj++) begin : g_col
         assign pixel_values[PIXEL_WIDTH*win_idx(gi, gj) +: PIXEL_WIDTH] = r_pix[gj];
      end
   end

   assign window_valid = r_valid;
   assign window_last  = r_last;
endmodule

// File: tb/tb_window_generator.sv
// Bench for window_generator on a 4x4 image: a frame-array reference model
// predicts every window, checked per scenario task.
module tb_window_generator;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          frame_start = 1'b0;
   logic [PW-1:0] pixel_in = '0;
   logic          pixel_valid = 1'b0;
   logic [9*PW-1:0] pixel_values;
   logic          window_valid;
   logic          window_last;

   window_generator #(
      .IMAGE_WIDTH  (W),
      .IMAGE_HEIGHT (H),
      .PIXEL_WIDTH  (PW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .frame_start  (frame_start),
      .pixel_in     (pixel_in),
      .pixel_valid  (pixel_valid),
      .pixel_values (pixel_values),
      .window_valid (window_valid),
      .window_last  (window_last)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: the current frame as a 2D image plus the raster position.
   logic [PW-1:0]   img [H][W];
   int              m_y = 0, m_x = 0;
   logic            ev, el, ek;
   logic [9*PW-1:0] ew = '0;

   task automatic model_reset();
      m_y = 0; m_x = 0; ev = 0; el = 0; ek = 1; ew = '0;
   endtask

   // Drive one cycle, then compute what the outputs must be after that edge.
   task automatic step(input logic v, input logic fs, input logic [PW-1:0] p);
      pixel_valid = v; frame_start = fs; pixel_in = p;
      @(posedge clk); #1;
      pixel_valid = 0; frame_start = 0;
      if (fs) begin m_y = 0; m_x = 0; end
      ev = 0; el = 0;
      if (v) begin
         img[m_y][m_x] = p;
         if (m_y >= 2 && m_x >= 2) begin
            ev = 1; ek = 1;
            el = (m_y == H-1) && (m_x == W-1);
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 3; c++)
                  ew[PW*(3*r+c) +: PW] = img[m_y-2+r][m_x-2+c];
            $display("window centre (%0d,%0d) expected %h last=%0b", m_y-1, m_x-1, ew, el);
         end else begin
            ek = 0;
         end
         m_x++;
         if (m_x == W) begin m_x = 0; m_y = (m_y + 1) % H; end
      end
   endtask

   task automatic test_reset();
      reset = 1;
      @(posedge clk); @(posedge clk); #1;
      total++; if (pixel_values !== '0) begin bad++; $display("FAIL reset pixel_values got %h want 0", pixel_values); end
      total++; if (window_valid !== 1'b0) begin bad++; $display("FAIL reset window_valid got %b want 0", window_valid); end
      total++; if (window_last !== 1'b0) begin bad++; $display("FAIL reset window_last got %b want 0", window_last); end
      reset = 0;
      model_reset();
   endtask

   task automatic test_basic(input bit gapped);
      int nwin = 0, nlast = 0, first_idx = -1;
      logic [9*PW-1:0] first_win = '0;
      step(0, 1, 0);
      for (int i = 0; i < W*H; i++) begin
         for (int g = 0; g <= (gapped ? 3 : 0); g++) begin
            if (g == 0) step(1, 0, PW'(16*(i/W) + (i%W)));
            else        step(0, 0, PW'($urandom));
            total++; if (window_valid !== ev) begin bad++; $display("FAIL basic(gap=%0b) valid px%0d g%0d got %b want %b", gapped, i, g, window_valid, ev); end
            total++; if (window_last !== el) begin bad++; $display("FAIL basic(gap=%0b) last px%0d g%0d got %b want %b", gapped, i, g, window_last, el); end
            if (ek) begin
               total++; if (pixel_values !== ew) begin bad++; $display("FAIL basic(gap=%0b) window px%0d g%0d got %h want %h", gapped, i, g, pixel_values, ew); end
            end
            if (window_valid === 1'b1) begin
               nwin++;
               if (first_idx < 0) begin first_idx = i; first_win = pixel_values; end
            end
            if (window_last === 1'b1) nlast++;
         end
      end
      total++; if (first_idx != 10) begin bad++; $display("FAIL basic(gap=%0b) first window after pixel %0d want 10", gapped, first_idx); end
      total++; if (first_win !== 72'h22_21_20_12_11_10_02_01_00) begin bad++; $display("FAIL basic(gap=%0b) first window got %h want 222120121110020100", gapped, first_win); end
      total++; if (nwin != 4) begin bad++; $display("FAIL basic(gap=%0b) window count got %0d want 4", gapped, nwin); end
      total++; if (nlast != 1) begin bad++; $display("FAIL basic(gap=%0b) last count got %0d want 1", gapped, nlast); end
   endtask

   task automatic test_auto_restart();
      int nwin = 0, nlast = 0;
      step(0, 1, 0);
      for (int i = 0; i < 2*W*H; i++) begin
         step(1, 0, (i < W*H) ? PW'($urandom_range(0, 127)) : PW'($urandom_range(128, 255)));
         total++; if (window_valid !== ev) begin bad++; $display("FAIL restart valid px%0d got %b want %b", i, window_valid, ev); end
         total++; if (window_last !== el) begin bad++; $display("FAIL restart last px%0d got %b want %b", i, window_last, el); end
         if (ek) begin
            total++; if (pixel_values !== ew) begin bad++; $display("FAIL restart window px%0d got %h want %h", i, pixel_values, ew); end
         end
         if (window_valid === 1'b1) nwin++;
         if (window_last === 1'b1) nlast++;
      end
      total++; if (nwin != 8) begin bad++; $display("FAIL restart window count got %0d want 8", nwin); end
      total++; if (nlast != 2) begin bad++; $display("FAIL restart last count got %0d want 2", nlast); end
   endtask

   task automatic test_mid_restart();
      int nwin = 0, first_idx = -1;
      step(0, 1, 0);
      for (int i = 0; i < 7; i++) begin
         step(1, 0, PW'($urandom_range(0, 127)));
         total++; if (window_valid !== 1'b0) begin bad++; $display("FAIL midrestart old px%0d valid got %b want 0", i, window_valid); end
      end
      for (int i = 0; i < W*H; i++) begin
         step(1, (i == 0), PW'($urandom_range(128, 255)));
         total++; if (window_valid !== ev) begin bad++; $display("FAIL midrestart valid px%0d got %b want %b", i, window_valid, ev); end
         total++; if (window_last !== el) begin bad++; $display("FAIL midrestart last px%0d got %b want %b", i, window_last, el); end
         if (ek) begin
            total++; if (pixel_values !== ew) begin bad++; $display("FAIL midrestart window px%0d got %h want %h", i, pixel_values, ew); end
         end
         if (window_valid === 1'b1) begin nwin++; if (first_idx < 0) first_idx = i; end
      end
      total++; if (first_idx != 10) begin bad++; $display("FAIL midrestart first window after pixel %0d want 10", first_idx); end
      total++; if (nwin != 4) begin bad++; $display("FAIL midrestart window count got %0d want 4", nwin); end
   endtask

   task automatic test_async_reset();
      int nwin = 0, first_idx = -1;
      step(0, 1, 0);
      for (int i = 0; i < 11; i++) begin
         step(1, 0, PW'($urandom));
         total++; if (window_valid !== ev) begin bad++; $display("FAIL areset pre valid px%0d got %b want %b", i, window_valid, ev); end
      end
      #3 reset = 1;
      #1;
      total++; if (pixel_values !== '0) begin bad++; $display("FAIL areset pixel_values got %h want 0", pixel_values); end
      total++; if (window_valid !== 1'b0) begin bad++; $display("FAIL areset window_valid got %b want 0", window_valid); end
      total++; if (window_last !== 1'b0) begin bad++; $display("FAIL areset window_last got %b want 0", window_last); end
      @(posedge clk); #1;
      reset = 0;
      model_reset();
      for (int i = 0; i < W*H; i++) begin
         step(1, 0, PW'($urandom));
         total++; if (window_valid !== ev) begin bad++; $display("FAIL areset valid px%0d got %b want %b", i, window_valid, ev); end
         if (ek) begin
            total++; if (pixel_values !== ew) begin bad++; $display("FAIL areset window px%0d got %h want %h", i, pixel_values, ew); end
         end
         if (window_valid === 1'b1) begin nwin++; if (first_idx < 0) first_idx = i; end
      end
      total++; if (first_idx != 10) begin bad++; $display("FAIL areset first window after pixel %0d want 10", first_idx); end
      total++; if (nwin != 4) begin bad++; $display("FAIL areset window count got %0d want 4", nwin); end
   endtask

   task automatic test_random();
      step(0, 1, 0);
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0), PW'($urandom));
         total++; if (window_valid !== ev) begin bad++; $display("FAIL random valid cyc%0d got %b want %b", i, window_valid, ev); end
         total++; if (window_last !== el) begin bad++; $display("FAIL random last cyc%0d got %b want %b", i, window_last, el); end
         if (ek) begin
            total++; if (pixel_values !== ew) begin bad++; $display("FAIL random window cyc%0d got %h want %h", i, pixel_values, ew); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic(1'b0);
      test_basic(1'b1);
      test_auto_restart();
      test_mid_restart();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/window_generator.md
Name: window_generator

Overview:
- Streaming producer of 3x3 pixel neighbourhoods for the convolution/sobel path. Accepts one raster-order 8-bit pixel per valid cycle.
- Buffers the two previous image rows in line buffers and emits the 72-bit window bus that the sobel filter consumes.
- Sits between the camera/frame reader and the filter stage. Valid-only streaming; no backpressure.

Parameters:
- IMAGE_WIDTH, 640, pixels per row (>=3)
- IMAGE_HEIGHT, 480, rows per frame (>=3)
- PIXEL_WIDTH, 8, bits per pixel (opaque RGB word)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- frame_start  input  1  pulse; clears row/column counters for a new frame
- pixel_in  input  PIXEL_WIDTH  raster-order pixel data
- pixel_valid  input  1  pixel_in accepted this cycle when high
- pixel_values  output  9*PIXEL_WIDTH  3x3 window, registered
- window_valid  output  1  pixel_values holds a complete window this cycle
- window_last  output  1  high with the final window of the frame

Behaviour:
- Reset (asynchronous, active-high): col=0, row=0, all window registers 0, pixel_values=0, window_valid=0, window_last=0. Line buffer contents are not cleared; they are don't-care until refilled.
- Window packing: element k = 3*r + c, where r=0 is the top (oldest) row and c=0 is the left (oldest) column. Element k occupies bits [PIXEL_WIDTH*k +: PIXEL_WIDTH]. Element 8 is the newest pixel, at the bottom-right.
- Line buffers: lb0 holds row-1 and lb1 holds row-2, each IMAGE_WIDTH x PIXEL_WIDTH, indexed by col.
- On an accepted pixel, read before write:
  - new column = {lb1[col], lb0[col], pixel_in}, top to bottom.
  - Then lb1[col] <= lb0[col] and lb0[col] <= pixel_in.
- Window shift: the 3x3 registers shift one column left; the new column enters at c=2.
- Counters: col increments per accepted pixel and wraps at IMAGE_WIDTH-1 to 0. On wrap, row increments and wraps at IMAGE_HEIGHT-1 to 0, so a frame auto-restarts without frame_start.
- window_valid: registered, high exactly one cycle after accepting a pixel at row>=2 && col>=2. Latency is 1 clk.
- Window count per frame is (IMAGE_WIDTH-2)*(IMAGE_HEIGHT-2). The window is centred at (row-1, col-1).
- Windows are never emitted across a row boundary; stale columns from the previous row are masked by the col>=2 condition.
- window_last: asserted with window_valid for the pixel accepted at (IMAGE_HEIGHT-1, IMAGE_WIDTH-1).
- pixel_valid low: no state change; window_valid=0 next cycle; pixel_values holds its last value.
- frame_start alone: col=row=0 next cycle; no pixel consumed.
- frame_start together with pixel_valid: that pixel is taken as (0,0) and the counters advance to col=1, row=0.
- frame_start mid-frame: the partial frame is abandoned. No window is emitted until two fresh rows have been received.
- Reset mid-frame: behaves identically to frame_start, plus the outputs clear immediately.
- Line buffer address width is clog2(IMAGE_WIDTH). Only indices 0..IMAGE_WIDTH-1 are ever accessed.

Decomposition:
- Shared definitions file holds:
  - PIXEL_WIDTH (8), WINDOW_PIXELS (9), WINDOW_BUS_WIDTH (72)
  - default IMAGE_WIDTH and IMAGE_HEIGHT
  - the window element index constants
- One sub-module, line_buffer: a parameterised DEPTH x WIDTH memory with synchronous write and read-before-write at the same address.
  - It is instantiated twice, or once at 2*PIXEL_WIDTH width carrying both rows.
- Counters and the 3x3 register array stay in window_generator.

Test Plan:
- Basic window check:
  - Setup: IMAGE_WIDTH=4, IMAGE_HEIGHT=4, frame_start, then pixel (y,x) = 16*y+x streamed continuously.
  - First window_valid occurs the cycle after pixel 0x22.
  - pixel_values = {22,21,20,12,11,10,02,01,00} hex, with element 8 leftmost.
- Full frame count: the same 4x4 frame yields exactly 4 windows, centred at (1,1), (1,2), (2,1), (2,2). window_last is high only on the 4th, which follows pixel 0x33.
- Gapped input: insert pixel_valid=0 for 3 cycles between every pixel. Window contents and count must match the first two tests; window_valid stays low during gaps.
- Auto-restart: stream two 4x4 frames back-to-back with no frame_start and distinct data. Each frame gives 4 windows and window_last fires twice; no window spans the two frames' rows 0-1.
- Mid-frame restart: after 7 pixels, pulse frame_start together with pixel_valid on pixel (0,0) of a new frame. No window_valid occurs until new pixel (2,2), whose window contains only new-frame data.
- Reset mid-operation: assert reset asynchronously mid-row. pixel_values=0, window_valid=0 and window_last=0 immediately. After release, the first window appears after 11 accepted pixels at IMAGE_WIDTH=4.
